// File: rtl/music_seq_ctrl.sv
// music_seq_ctrl: song select, play/pause and per-beat note-ROM address sequencing
module music_seq_ctrl #(
    parameter int          BEAT_CYC = 12_500_000,
    parameter logic [4:0]  END_CODE = 5'h1F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] music_reg,
    input  logic       play_key,
    input  logic [4:0] note_code,
    output logic [7:0] note_addr,
    output logic       note_en,
    output logic       cnt_clc,
    output logic       beat_tick,
    output logic [2:0] state_o
);
    localparam int BW = $clog2(BEAT_CYC);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYC - 1);

    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, CHECK = 3'd2, PLAY = 3'd3, PAUSE = 3'd4} state_t;

    state_t          state, state_n;
    logic [1:0]      song_q, song_n;
    logic [5:0]      idx, idx_n;
    logic [BW-1:0]   beat_cnt, beat_n;
    logic            clc_n, tick_n, active, song_chg;

    assign active    = state inside {FETCH, CHECK, PLAY, PAUSE};
    assign song_chg  = music_reg != song_q;
    assign note_addr = {song_q, idx};
    assign state_o   = state;

    always_comb begin
        state_n = state;
        song_n  = song_q;
        idx_n   = idx;
        beat_n  = beat_cnt;
        clc_n   = 1'b0;
        tick_n  = 1'b0;
        // A song change outranks any key press or beat end in the same cycle
        if (active && song_chg) begin
            idx_n  = '0;
            beat_n = '0;
            clc_n  = 1'b1;
            if (music_reg == 2'd0) begin
                state_n = IDLE;
            end else begin
                song_n  = music_reg;
                state_n = (state == PAUSE) ? PAUSE : FETCH;
            end
        end else begin
            case (state)
                IDLE: if (play_key && music_reg != 2'd0) begin
                    song_n  = music_reg;
                    idx_n   = '0;
                    beat_n  = '0;
                    clc_n   = 1'b1;
                    state_n = FETCH;
                end
                FETCH: state_n = CHECK;
                CHECK: begin
                    if (note_code != END_CODE) begin
                        state_n = PLAY;
                    end else if (idx != 6'd0) begin
                        idx_n   = '0;
                        clc_n   = 1'b1;
                        state_n = FETCH;
                    end else begin
                        state_n = IDLE;
                    end
                end
                PLAY: begin
                    if (play_key) begin
                        state_n = PAUSE;
                    end else if (beat_cnt == BEAT_LAST) begin
                        beat_n  = '0;
                        tick_n  = 1'b1;
                        idx_n   = idx + 6'd1;
                        clc_n   = idx == 6'd63;
                        state_n = FETCH;
                    end else begin
                        beat_n = beat_cnt + 1'b1;
                    end
                end
                PAUSE: state_n = play_key ? FETCH : PAUSE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            song_q    <= '0;
            idx       <= '0;
            beat_cnt  <= '0;
            cnt_clc   <= 1'b0;
            beat_tick <= 1'b0;
            note_en   <= 1'b0;
        end else begin
            state     <= state_n;
            song_q    <= song_n;
            idx       <= idx_n;
            beat_cnt  <= beat_n;
            cnt_clc   <= clc_n;
            beat_tick <= tick_n;
            note_en   <= state_n == PLAY;
        end
    end
endmodule

// File: tb/tb_music_seq_ctrl.sv
// tb_music_seq_ctrl: scoreboard bench with a behavioural player model and a synchronous note ROM
module tb_music_seq_ctrl;
    localparam int BEAT = 4;
    localparam logic [4:0] END = 5'h1F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] music_reg = 2'd0;
    logic       play_key = 1'b0;
    logic [4:0] note_code = 5'd0;
    logic [7:0] note_addr;
    logic       note_en, cnt_clc, beat_tick;
    logic [2:0] state_o;

    music_seq_ctrl #(.BEAT_CYC(BEAT), .END_CODE(END)) dut (
        .clk(clk), .rst(rst), .music_reg(music_reg), .play_key(play_key),
        .note_code(note_code), .note_addr(note_addr), .note_en(note_en),
        .cnt_clc(cnt_clc), .beat_tick(beat_tick), .state_o(state_o)
    );

    always #5 clk = ~clk;

    logic [4:0] rom [256];
    always @(posedge clk) note_code <= rom[note_addr];

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] addr;
        logic       en;
        logic       clc;
        logic       tick;
    } obs_t;

    obs_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Player model: what the listener sees, one clock at a time
    int m_state = 0, m_song = 0, m_idx = 0, m_beat = 0;

    task automatic model_step(input logic r, input logic pk, input logic [1:0] mr);
        bit clc = 0, tick = 0;
        if (r) begin
            m_state = 0; m_song = 0; m_idx = 0; m_beat = 0;
        end else if (m_state == 0) begin
            if (pk && mr != 0) begin
                m_song = mr; m_idx = 0; m_beat = 0; clc = 1; m_state = 1;
            end
        end else if (int'(mr) != m_song) begin
            m_idx = 0; m_beat = 0; clc = 1;
            if (mr == 0) m_state = 0;
            else begin
                m_song = mr;
                if (m_state != 4) m_state = 1;
            end
        end else if (m_state == 1) begin
            m_state = 2;
        end else if (m_state == 2) begin
            if (rom[m_song * 64 + m_idx] != END) m_state = 3;
            else if (m_idx != 0) begin m_idx = 0; clc = 1; m_state = 1; end
            else m_state = 0;
        end else if (m_state == 3) begin
            if (pk) m_state = 4;
            else if (m_beat == BEAT - 1) begin
                m_beat = 0; tick = 1; m_idx = (m_idx + 1) % 64;
                clc = (m_idx == 0);
                m_state = 1;
            end else m_beat++;
        end else if (pk) begin
            m_state = 1;
        end
        exp_q.push_back('{st: 3'(m_state), addr: 8'(m_song * 64 + m_idx),
                          en: m_state == 3, clc: clc, tick: tick});
    endtask

    task automatic tick(input logic r, input logic pk, input logic [1:0] mr);
        @(negedge clk);
        #1;
        rst = r; play_key = pk; music_reg = mr;
        @(posedge clk);
        model_step(r, pk, mr);
    endtask

    task automatic run(input int n, input logic [1:0] mr);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, mr);
    endtask

    task automatic run_until(input int st, input int beat, input logic [1:0] mr);
        for (int i = 0; i < 100 && !(m_state == st && (beat < 0 || m_beat == beat)); i++)
            tick(1'b0, 1'b0, mr);
    endtask

    task automatic fill_rom(input int e1, input int e2, input int e3);
        for (int a = 0; a < 256; a++) rom[a] = 5'($urandom_range(0, 30));
        if (e1 >= 0) rom[64 + e1] = END;
        if (e2 >= 0) rom[128 + e2] = END;
        if (e3 >= 0) rom[192 + e3] = END;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = '{st: state_o, addr: note_addr, en: note_en, clc: cnt_clc, tick: beat_tick};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t: got st=%0d addr=%h en=%b clc=%b tick=%b, want st=%0d addr=%h en=%b clc=%b tick=%b",
                         vectors, $time, a.st, a.addr, a.en, a.clc, a.tick, e.st, e.addr, e.en, e.clc, e.tick);
            end
        end
    end

    initial begin
        logic [1:0] mr;
        fill_rom(3, -1, 0);
        tick(1'b1, 1'b0, 2'd0);
        tick(1'b1, 1'b0, 2'd0);
        run(2, 2'd1);
        // Start song 1: loops at the end marker after three beats
        tick(1'b0, 1'b1, 2'd1);
        run(40, 2'd1);
        // Song change mid-note
        run_until(3, 1, 2'd1);
        run(12, 2'd2);
        // Pause at beat_cnt 2, hold, resume
        run_until(3, 2, 2'd2);
        tick(1'b0, 1'b1, 2'd2);
        run(10, 2'd2);
        tick(1'b0, 1'b1, 2'd2);
        run(12, 2'd2);
        // Deselect while playing, then a key with no song
        run_until(3, -1, 2'd2);
        run(5, 2'd0);
        tick(1'b0, 1'b1, 2'd0);
        run(3, 2'd0);
        // Empty song 3 returns straight to IDLE
        tick(1'b0, 1'b1, 2'd3);
        run(8, 2'd3);
        // Key in the same cycle as a song change is dropped
        tick(1'b0, 1'b1, 2'd1);
        run_until(3, -1, 2'd1);
        tick(1'b0, 1'b1, 2'd2);
        // Song 2 has no end marker: runs past the 63->0 wrap
        run(400, 2'd2);
        // Reset in the middle of a pause
        run_until(3, -1, 2'd2);
        tick(1'b0, 1'b1, 2'd2);
        run(3, 2'd2);
        tick(1'b1, 1'b0, 2'd2);
        run(3, 2'd2);
        // Random traffic, ROM end markers reshuffled under reset
        mr = 2'd1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                fill_rom($urandom_range(0, 70) - 2, $urandom_range(0, 70) - 2, $urandom_range(0, 70) - 2);
                tick(1'b1, 1'b0, mr);
            end else begin
                if ($urandom_range(0, 39) == 0) mr = 2'($urandom_range(0, 3));
                tick(1'b0, $urandom_range(0, 7) == 0, mr);
            end
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/music_seq_ctrl.md
# music_seq_ctrl

Playback sequencer for the music player. It tracks the selected song (`music_reg`) and a play/pause key, and steps a note-ROM address once per beat. It also issues the one-cycle `cnt_clc` clear pulse that resets downstream tone/beat counters whenever playback restarts or the song changes. It sits between the key/switch front end and the note ROM plus tone generator, and owns all sequencing of that datapath.

## Interface
- `BEAT_CYC`, 12_500_000: clock cycles per note beat (0.25 s at 50 MHz); minimum 2.
- `END_CODE`, 5'h1F: note code marking end of song in the ROM.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high; one clock domain only.
- `music_reg` in 2: song select; 0 = none, 1..3 = song number; level, may change at any time.
- `play_key` in 1: single-cycle debounced pulse that toggles play/pause.
- `note_code` in 5: ROM data for `note_addr`; ROM is synchronous, with 1-cycle read latency.
- `note_addr` out 8: {song_q[1:0], idx[5:0]}; registered.
- `note_en` out 1: tone generator enable; high only in PLAY.
- `cnt_clc` out 1: one-cycle clear pulse for downstream counters.
- `beat_tick` out 1: one-cycle pulse at each beat end.
- `state_o` out 3: current state encoding, for LEDs/debug.

## Operation
- State encodings: IDLE=0, FETCH=1, CHECK=2, PLAY=3, PAUSE=4. Any other code goes to IDLE.
- Internal registers: `song_q[1:0]`, `idx[5:0]`, `beat_cnt` (width = clog2(BEAT_CYC)).
- Song change: `music_reg != song_q`, evaluated in every state except IDLE.
- Event priority: rst > song change > play_key > end of beat.
- **IDLE**
  - `play_key` with `music_reg != 0`: `song_q <= music_reg`, `idx <= 0`, `beat_cnt <= 0`, pulse `cnt_clc`, go to FETCH.
  - `play_key` with `music_reg == 0`: ignored.
- **FETCH** (1 cycle): waits out the ROM latency, then goes to CHECK.
- **CHECK** (1 cycle): examines `note_code`.
  - Not END_CODE: go to PLAY.
  - END_CODE with `idx != 0`: `idx <= 0`, pulse `cnt_clc`, go to FETCH (song loops).
  - END_CODE with `idx == 0`: empty song, go to IDLE.
- **PLAY**
  - `beat_cnt` increments each cycle.
  - At `beat_cnt == BEAT_CYC-1`: `beat_cnt <= 0`, pulse `beat_tick`, `idx <= idx+1`, go to FETCH.
  - `idx` wraps 63 to 0; that wrap also pulses `cnt_clc`.
  - `play_key`: go to PAUSE with `beat_cnt` held.
- **PAUSE**
  - `note_en` = 0; `beat_cnt` and `idx` are frozen.
  - `play_key`: go to FETCH. Resume continues the same note from the held `beat_cnt`.
- Song change handling (FETCH/CHECK/PLAY/PAUSE):
  - New `music_reg == 0`: go to IDLE, pulse `cnt_clc`, `idx <= 0`, `beat_cnt <= 0`.
  - Otherwise: `song_q <= music_reg`, `idx <= 0`, `beat_cnt <= 0`, pulse `cnt_clc`.
  - From PAUSE: stay in PAUSE. From all other states: go to FETCH.
- A `play_key` arriving in the same cycle as a song change is dropped.
- `play_key` in FETCH or CHECK is ignored.

## Timing
- All outputs are registered.
- Reset values: `state_o`=0, `note_addr`=0, `note_en`=0, `cnt_clc`=0, `beat_tick`=0, `song_q`=0, `idx`=0, `beat_cnt`=0.
- `rst` asserted in any state returns the block to IDLE on the next edge with no `cnt_clc` pulse.
- `cnt_clc`, `beat_tick`, `note_addr` and `state_o` update on the same edge as the state transition that causes them. Pulses last exactly 1 cycle.
- `note_en` is high on every cycle where `state_o`=3.
- Each uninterrupted note lasts BEAT_CYC cycles of PLAY plus 2 cycles (FETCH+CHECK) with `note_en` low. Beat period is therefore BEAT_CYC+2 cycles.
- Play start latency: `play_key` at edge N gives FETCH at N+1, CHECK at N+2, PLAY/`note_en`=1 at N+3.
- `note_code` is sampled only in CHECK, which is 2 edges after `note_addr` last changed.

## Test plan
- **Start:** BEAT_CYC=4, `rst` 2 cycles, `music_reg`=1, `play_key` pulse.
  - Expect `cnt_clc` once and `note_addr`=0x40.
  - Expect `note_en` high 4 cycles, `beat_tick`, then `note_addr`=0x41.
- **Song change mid-note:** switch `music_reg` 1→2 during PLAY.
  - Expect `cnt_clc` pulse the next cycle, `note_addr`=0x80, FETCH, and PLAY again 2 cycles later.
- **Pause/resume:** `play_key` at `beat_cnt`=2, hold 10 cycles, then `play_key`.
  - Expect `note_en`=0 throughout the pause, `note_addr` unchanged.
  - After resume, exactly 2 PLAY cycles before `beat_tick`.
- **End marker:** ROM model returns END_CODE at idx 3.
  - Expect `cnt_clc` pulse, `idx` 0, looping; `beat_tick` count per loop = 3.
  - With END_CODE at idx 0, expect return to IDLE and `note_en` never asserted.
- **Deselect and collisions:**
  - `music_reg`→0 in PLAY: expect IDLE with one `cnt_clc` pulse.
  - `play_key` in the same cycle as a song change: expect it ignored.
  - `play_key` in IDLE with `music_reg`=0: expect no state change.
- **Reset mid-PAUSE:** expect all outputs 0 and `state_o`=0 the next cycle, with no `cnt_clc` pulse.
